// File: rtl/nnl_stream_pkg.sv
// Shared definitions for the layer streaming interface: FSM state codes and frame sizing.
// Used by stream sources, future stream sinks and the bench.
package nnl_stream_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    // Number of pixels in one streamed frame, with an optional 1-pixel zero border.
    function automatic int unsigned frame_pixels(input int unsigned w, input int unsigned h,
                                                 input bit pad);
        return pad ? (w + 2) * (h + 2) : w * h;
    endfunction

endpackage

// File: rtl/fm_buffer_ram.sv
// Simple dual-port feature-map RAM: one write port, one read port, read-first,
// 1-cycle registered read. Contents are never cleared; only the read register resets.
module fm_buffer_ram #(
    parameter int unsigned WIDTH  = 256,
    parameter int unsigned DEPTH  = 1936,
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Both processes sample mem before the edge, so a same-address collision reads old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/feature_map_streamer.sv
// Feature-map stream source: holds one frame in RAM and emits it in raster order on Start.
// Optional zero border around the frame is enabled by defining FMS_PADDING_EN.
module feature_map_streamer
    import nnl_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDHT = 32,
    parameter int unsigned CHANNEL    = 8,
    parameter int unsigned IMG_WIDTH  = 44,
    parameter int unsigned IMG_HEIGHT = 44,
    parameter int unsigned ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          Wr_En,
    input  logic [ADDR_W-1:0]             Wr_Addr,
    input  logic [DATA_WIDHT*CHANNEL-1:0] Wr_Data,
    input  logic                          Start,
    input  logic                          Hold,
    output logic [DATA_WIDHT*CHANNEL-1:0] Data_Out,
    output logic                          Valid_Out,
    output logic                          Last_Out,
    output logic                          Busy,
    output logic                          Done
);

    localparam int unsigned WW = DATA_WIDHT * CHANNEL;
`ifdef FMS_PADDING_EN
    localparam int unsigned FW = IMG_WIDTH + 2;
    localparam int unsigned FH = IMG_HEIGHT + 2;
`else
    localparam int unsigned FW = IMG_WIDTH;
    localparam int unsigned FH = IMG_HEIGHT;
`endif
    localparam int unsigned CW = $clog2(FW);
    localparam int unsigned RW = $clog2(FH);

    logic [1:0]        state;
    logic              start_q;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [ADDR_W-1:0] rd_addr;
    logic              issue;
    logic              at_last;
    logic              rd_en;
    logic              valid_q;
    logic              last_q;
    logic [WW-1:0]     ram_q;

    assign issue   = (state == ST_ISSUE) && !Hold;
    assign at_last = (col == CW'(FW - 1)) && (row == RW'(FH - 1));

`ifdef FMS_PADDING_EN
    logic border;
    logic border_q;

    assign border = (col == '0) || (row == '0) || (col == CW'(FW - 1)) || (row == RW'(FH - 1));
    assign rd_en  = issue && !border;

    // Border flag travels alongside the RAM read so latency matches interior pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            border_q <= 1'b0;
        end else if (issue) begin
            border_q <= border;
        end
    end

    assign Data_Out = border_q ? '0 : ram_q;
`else
    assign rd_en    = issue;
    assign Data_Out = ram_q;
`endif

    fm_buffer_ram #(
        .WIDTH (WW),
        .DEPTH (IMG_WIDTH * IMG_HEIGHT),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (Wr_En),
        .wr_addr(Wr_Addr),
        .wr_data(Wr_Data),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(ram_q)
    );

    // Start is registered first, giving ISSUE one edge after Start is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            start_q <= 1'b0;
            col     <= '0;
            row     <= '0;
            rd_addr <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            start_q <= Start && (state == ST_IDLE);
            valid_q <= issue;
            last_q  <= issue && at_last;
            if (rd_en) begin
                rd_addr <= rd_addr + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start_q) begin
                        state   <= ST_ISSUE;
                        col     <= '0;
                        row     <= '0;
                        rd_addr <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (issue) begin
                        if (col == CW'(FW - 1)) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (at_last) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (last_q) begin
                        state <= ST_FINISH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign Valid_Out = valid_q;
    assign Last_Out  = last_q;
    assign Busy      = (state != ST_IDLE);
    assign Done      = (state == ST_FINISH);

endmodule

// File: tb/tb_feature_map_streamer.sv
// Directed self-checking bench for feature_map_streamer (default and FMS_PADDING_EN builds).
module tb_feature_map_streamer;
    import nnl_stream_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned CH = 8;
    localparam int unsigned IW = 44;
    localparam int unsigned IH = 44;
    localparam int unsigned AW = $clog2(IW * IH);
    localparam int unsigned WW = DW * CH;
`ifdef FMS_PADDING_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif
    localparam int unsigned NPIX = frame_pixels(IW, IH, PAD);
    localparam int unsigned PC   = 1201;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          Wr_En = 1'b0;
    logic [AW-1:0] Wr_Addr = '0;
    logic [WW-1:0] Wr_Data = '0;
    logic          Start = 1'b0;
    logic          Hold = 1'b0;
    logic [WW-1:0] Data_Out;
    logic          Valid_Out;
    logic          Last_Out;
    logic          Busy;
    logic          Done;

    feature_map_streamer #(
        .DATA_WIDHT(DW),
        .CHANNEL   (CH),
        .IMG_WIDTH (IW),
        .IMG_HEIGHT(IH),
        .ADDR_W    (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Wr_En    (Wr_En),
        .Wr_Addr  (Wr_Addr),
        .Wr_Data  (Wr_Data),
        .Start    (Start),
        .Hold     (Hold),
        .Data_Out (Data_Out),
        .Valid_Out(Valid_Out),
        .Last_Out (Last_Out),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int k = 0;
    logic [31:0] model_mem [IW*IH];

    logic [WW-1:0] cap_q [$];
    int            cyc_q [$];
    int            last_cnt = 0;
    int            last_idx = -1;
    int            last_cyc = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (Valid_Out) begin
            cap_q.push_back(Data_Out);
            cyc_q.push_back(cyc);
        end
        if (Last_Out) begin
            last_cnt++;
            last_idx = Valid_Out ? cap_q.size() - 1 : -1;
            last_cyc = cyc;
        end
        if (Done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] rep(input logic [31:0] v);
        return {CH{v}};
    endfunction

    function automatic int unsigned addr_of(input int unsigned i);
`ifdef FMS_PADDING_EN
        return (i / (IW + 2) - 1) * IW + (i % (IW + 2) - 1);
`else
        return i;
`endif
    endfunction

    function automatic int unsigned pixel_of(input int unsigned a);
`ifdef FMS_PADDING_EN
        return (a / IW + 1) * (IW + 2) + (a % IW + 1);
`else
        return a;
`endif
    endfunction

    function automatic logic [WW-1:0] exp_pix(input int unsigned i);
`ifdef FMS_PADDING_EN
        int unsigned r = i / (IW + 2);
        int unsigned c = i % (IW + 2);
        if (r == 0 || c == 0 || r == IH + 1 || c == IW + 1) return '0;
        return rep(model_mem[(r - 1) * IW + (c - 1)]);
`else
        return rep(model_mem[i]);
`endif
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        cap_q.delete();
        cyc_q.delete();
        last_cnt = 0;
        last_idx = -1;
        last_cyc = 0;
        done_cnt = 0;
        done_cyc = 0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        step(1);
        Start = 1'b0;
        k = cyc;
    endtask

    task automatic wait_done();
        for (int n = 0; n < int'(NPIX) + 200; n++) begin
            @(negedge clk);
            if (Done) break;
        end
        check("done_seen", Done, 1'b1);
        @(negedge clk);
        check("busy_after_done", Busy, 1'b0);
    endtask

    task automatic verify_frame(input int gap);
        check("frame_len", cap_q.size(), NPIX);
        for (int unsigned i = 0; i < NPIX && i < cap_q.size(); i++) begin
            check($sformatf("pixel%0d", i), cap_q[i], exp_pix(i));
        end
        check("last_count", last_cnt, 1);
        check("last_idx", last_idx, NPIX - 1);
        check("done_count", done_cnt, 1);
        check("done_after_last", done_cyc - last_cyc, 1);
        check("stream_span", last_cyc - cyc_q[0], int'(NPIX) - 1 + gap);
    endtask

    initial begin
        step(3);
        @(negedge clk);
        check("rst_data", Data_Out, '0);
        check("rst_valid", Valid_Out, 1'b0);
        check("rst_last", Last_Out, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_done", Done, 1'b0);
        step(1);
        rst = 1'b0;

        for (int unsigned a = 0; a < IW * IH; a++) begin
            Wr_En   = 1'b1;
            Wr_Addr = AW'(a);
            Wr_Data = rep(a);
            model_mem[a] = a;
            step(1);
        end
        Wr_En = 1'b0;
        step(2);

        // Basic frame with start latency
        clr();
        pulse_start();
        @(negedge clk);
        check("busy_at_k", Busy, 1'b0);
        check("valid_at_k", Valid_Out, 1'b0);
        @(negedge clk);
        check("busy_at_k1", Busy, 1'b1);
        check("valid_at_k1", Valid_Out, 1'b0);
        @(negedge clk);
        check("valid_at_k2", Valid_Out, 1'b1);
        check("data_at_k2", Data_Out, exp_pix(0));
        wait_done();
        verify_frame(0);
`ifdef FMS_PADDING_EN
        check("pad_interior_11", cap_q[IW + 3], rep(model_mem[0]));
        check("pad_corner", cap_q[0], '0);
`endif
        step(3);

        // Hold for 5 cycles right after pixel 100 is issued
        clr();
        pulse_start();
        step(102);
        Hold = 1'b1;
        step(5);
        Hold = 1'b0;
        wait_done();
        verify_frame(5);
        check("hold_gap", cyc_q[101] - cyc_q[100], 6);
        check("hold_pre", cyc_q[100] - cyc_q[0], 100);
        step(3);

        // Start pulses while busy are ignored
        clr();
        pulse_start();
        step(50);
        Start = 1'b1;
        step(1);
        Start = 1'b0;
        step(300);
        Start = 1'b1;
        step(1);
        Start = 1'b0;
        wait_done();
        verify_frame(0);
        step(20);
        check("no_second_busy", Busy, 1'b0);
        check("no_second_frame", cap_q.size(), NPIX);

        // Reset mid-frame at pixel 500
        clr();
        pulse_start();
        step(502);
        rst = 1'b1;
        step(1);
        @(negedge clk);
        check("abort_valid", Valid_Out, 1'b0);
        check("abort_busy", Busy, 1'b0);
        check("abort_last", Last_Out, 1'b0);
        check("abort_data", Data_Out, '0);
        step(1);
        rst = 1'b0;
        step(10);
        check("abort_cap", cap_q.size(), 501);
        check("abort_no_done", done_cnt, 0);
        check("abort_idle", Busy, 1'b0);
        clr();
        pulse_start();
        wait_done();
        verify_frame(0);
        step(3);

        // Writes during streaming: ahead of the read, and colliding with it
        clr();
        pulse_start();
        step(401);
        Wr_En   = 1'b1;
        Wr_Addr = AW'(1000);
        Wr_Data = rep(32'hDEADBEEF);
        model_mem[1000] = 32'hDEADBEEF;
        step(1);
        Wr_En = 1'b0;
        step(PC + 1 - 402);
        Wr_En   = 1'b1;
        Wr_Addr = AW'(addr_of(PC));
        Wr_Data = rep(32'hCAFEF00D);
        step(1);
        Wr_En = 1'b0;
        wait_done();
        verify_frame(0);
        check("beef_pixel", cap_q[pixel_of(1000)], rep(32'hDEADBEEF));
        check("collide_old", cap_q[PC], rep(addr_of(PC)));
        model_mem[addr_of(PC)] = 32'hCAFEF00D;
        step(3);
        clr();
        pulse_start();
        wait_done();
        verify_frame(0);
        check("collide_new", cap_q[PC], rep(32'hCAFEF00D));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
